mips_cpu_regfile_mp: RTL

- Parametrised multi-read-port MIPS general-purpose register file, successor to the single-pair register block.
- Supports a configurable data width, depth and number of read ports.
- Reads are registered with a per-port enable and write-to-read bypass.
- A pending-write scoreboard flags registers awaiting a load result.
- Sits between decode (read ports), writeback (write port) and the load unit (scoreboard set); exports v0 for the testbench.

---
 rtl/mips_cpu_regfile_mp.sv | 107 ++++++++++
 1 files changed

// File: rtl/mips_cpu_regfile_mp.sv
// Multi-read-port MIPS GPR file with registered reads, write-first bypass and a load scoreboard.
// Optional HI/LO register pair is enabled by defining MIPS_REGFILE_HILO_EN.
module mips_cpu_regfile_mp #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int N_RD    = 2,
  parameter int V0_ADDR = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     write,
  input  logic [ADDR_W-1:0]        wrAddr,
  input  logic [DATA_W-1:0]        wrData,
  input  logic [N_RD-1:0]          rdEn,
  input  logic [N_RD*ADDR_W-1:0]   rdAddr,
  output logic [N_RD*DATA_W-1:0]   rdData,
  output logic [N_RD-1:0]          rdBusy,
  input  logic                     pendSet,
  input  logic [ADDR_W-1:0]        pendAddr,
  output logic [(2**ADDR_W)-1:0]   busyVec,
`ifdef MIPS_REGFILE_HILO_EN
  input  logic                     hiloWrite,
  input  logic [DATA_W-1:0]        hiWrData,
  input  logic [DATA_W-1:0]        loWrData,
  output logic [DATA_W-1:0]        hiData,
  output logic [DATA_W-1:0]        loData,
`endif
  output logic [DATA_W-1:0]        register_v0
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] V0_A = ADDR_W'(V0_ADDR);

  logic [DATA_W-1:0]      regs_q [DEPTH];
  logic [DEPTH-1:0]       busy_q, busy_d;
  logic [N_RD*DATA_W-1:0] rd_data_q;
  logic [N_RD-1:0]        rd_busy_q;
  logic [ADDR_W-1:0]      rd_addr   [N_RD];
  logic [DATA_W-1:0]      rd_data_d [N_RD];
  logic [N_RD-1:0]        rd_upd;
  logic                   wr_en;

  assign wr_en = write && (wrAddr != '0);

  // Set after clear so a load issued in the same cycle as a writeback keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) busy_d[wrAddr] = 1'b0;
    if (pendSet && (pendAddr != '0)) busy_d[pendAddr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    for (int p = 0; p < N_RD; p++) begin
      rd_addr[p] = rdAddr[p*ADDR_W +: ADDR_W];
      rd_upd[p]  = rdEn[p] && !$isunknown(rdAddr[p*ADDR_W +: ADDR_W]);
      if (rd_addr[p] == '0)
        rd_data_d[p] = '0;
      else if (wr_en && (wrAddr == rd_addr[p]))
        rd_data_d[p] = wrData;
      else
        rd_data_d[p] = regs_q[rd_addr[p]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      busy_q    <= '0;
      rd_data_q <= '0;
      rd_busy_q <= '0;
    end else begin
      if (wr_en) regs_q[wrAddr] <= wrData;
      busy_q <= busy_d;
      for (int p = 0; p < N_RD; p++) begin
        if (rd_upd[p]) begin
          rd_data_q[p*DATA_W +: DATA_W] <= rd_data_d[p];
          rd_busy_q[p]                  <= busy_d[rd_addr[p]];
        end
      end
    end
  end

  assign rdData  = rd_data_q;
  assign rdBusy  = rd_busy_q;
  assign busyVec = busy_q;

  assign register_v0 = (wr_en && (wrAddr == V0_A) && !reset) ? wrData : regs_q[V0_A];

`ifdef MIPS_REGFILE_HILO_EN
  logic [DATA_W-1:0] hi_q, lo_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (hiloWrite) begin
      hi_q <= hiWrData;
      lo_q <= loWrData;
    end
  end

  assign hiData = hiloWrite ? hiWrData : hi_q;
  assign loData = hiloWrite ? loWrData : lo_q;
`endif

endmodule
